rv16_rd_wbq: RTL and testbench

RV16_RD_WBQ -- requirements
Module: rv16_rd_wbq

---
 rtl/rv16_pkg.sv | 49 ++++
 rtl/rv16_tag_fifo.sv | 55 +++++
 rtl/rv16_rd_wbq.sv | 125 ++++++++++++
 tb/tb_rv16_rd_wbq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv16_pkg.sv
// Shared opcode constants, FU channel enum and opcode decode for the writeback queue.
package rv16_pkg;

  // Opcode encodings of the supported arithmetic/logic operations.
  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpMul = 4'h2;
  localparam logic [3:0] OpDiv = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpAnd = 4'h5;
  localparam logic [3:0] OpOr  = 4'h6;

  // Width of an FU channel index as stored in a tag.
  localparam int unsigned FuChW = 3;

  typedef enum logic [FuChW-1:0] {
    FuAdd = 3'd0,
    FuSub = 3'd1,
    FuMul = 3'd2,
    FuDiv = 3'd3,
    FuXor = 3'd4,
    FuAnd = 3'd5,
    FuOr  = 3'd6
  } fu_ch_e;

  typedef struct packed {
    logic   legal;
    fu_ch_e ch;
  } op_dec_t;

  // Opcode arrives zero-extended so any upper bits beyond the 4-bit map make it illegal.
  function automatic op_dec_t decode_op(input logic [31:0] op);
    op_dec_t d;
    d.legal = 1'b1;
    d.ch    = FuAdd;
    case (op)
      {28'd0, OpAdd}: d.ch = FuAdd;
      {28'd0, OpSub}: d.ch = FuSub;
      {28'd0, OpMul}: d.ch = FuMul;
      {28'd0, OpDiv}: d.ch = FuDiv;
      {28'd0, OpXor}: d.ch = FuXor;
      {28'd0, OpAnd}: d.ch = FuAnd;
      {28'd0, OpOr}:  d.ch = FuOr;
      default:        d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv16_tag_fifo.sv
// In-order tag FIFO: DEPTH entries (power of two), head visible combinationally.
module rv16_tag_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage array; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/rv16_rd_wbq.sv
// Writeback queue: orders FU results by issue order and drives a single registered
// destination-register writeback port.
module rv16_rd_wbq
  import rv16_pkg::*;
#(
  parameter int unsigned DATA   = 16,
  parameter int unsigned OPCODE = 4,
  parameter int unsigned NFU    = 7,
  parameter int unsigned RADDR  = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [OPCODE-1:0]   issue_opcode,
  input  logic [RADDR-1:0]    issue_rd,
  output logic                issue_ready,
  output logic                issue_illegal,
  input  logic [NFU-1:0]      fu_valid,
  input  logic [NFU*DATA-1:0] fu_data,
  output logic [NFU-1:0]      fu_ack,
  output logic                rd_wb_valid,
  output logic [RADDR-1:0]    rd_wb_addr,
  output logic [DATA-1:0]     rd_wb_data,
  input  logic                rd_wb_ready,
  output logic                busy
);

  localparam int unsigned TagW = FuChW + RADDR;

  op_dec_t          w_dec;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [TagW-1:0]  w_tag_in;
  logic [TagW-1:0]  w_tag_out;
  logic [FuChW-1:0] w_head_ch;
  logic [RADDR-1:0] w_head_rd;
  logic             w_head_valid;
  logic [DATA-1:0]  w_head_data;
  logic [NFU-1:0]   w_head_oh;
  logic             w_out_free;

  logic             r_illegal;
  logic             r_wb_valid;
  logic [RADDR-1:0] r_wb_addr;
  logic [DATA-1:0]  r_wb_data;

  assign w_dec       = decode_op(32'(issue_opcode));
  assign issue_ready = ~w_full;
  assign w_fire      = issue_valid & issue_ready;
  assign w_push      = w_fire & w_dec.legal & ~rst;
  assign w_tag_in    = {w_dec.ch, issue_rd};

  assign w_head_ch   = w_tag_out[TagW-1 -: FuChW];
  assign w_head_rd   = w_tag_out[RADDR-1:0];

  rv16_tag_fifo #(
    .WIDTH (TagW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_tag_in),
    .o_rdata (w_tag_out),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Select the result channel named by the head tag; other channels are ignored.
  always_comb begin
    w_head_valid = 1'b0;
    w_head_data  = '0;
    w_head_oh    = '0;
    for (int i = 0; i < NFU; i++) begin
      if (w_head_ch == FuChW'(i)) begin
        w_head_valid = fu_valid[i];
        w_head_data  = fu_data[i*DATA +: DATA];
        w_head_oh[i] = 1'b1;
      end
    end
  end

  // Pop when the head result is present and the output register is free or draining.
  always_comb begin
    w_out_free = ~r_wb_valid | rd_wb_ready;
    w_pop      = ~w_empty & w_head_valid & w_out_free & ~rst;
    fu_ack     = w_pop ? w_head_oh : '0;
  end

  // Writeback register: load on pop, hold under back-pressure, clear after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (w_pop) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= w_head_rd;
      r_wb_data  <= w_head_data;
    end else if (rd_wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

  // One-cycle flag for a fired issue carrying an unmapped opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_fire & ~w_dec.legal;
    end
  end

  assign issue_illegal = r_illegal;
  assign rd_wb_valid   = r_wb_valid;
  assign rd_wb_addr    = r_wb_addr;
  assign rd_wb_data    = r_wb_data;
  assign busy          = ~w_empty | r_wb_valid;

endmodule

// File: tb/tb_rv16_rd_wbq.sv
// Directed bench for rv16_rd_wbq: writebacks are checked by a scoreboard monitor,
// control outputs by in-line checks.
module tb_rv16_rd_wbq;

  localparam int DATA   = 16;
  localparam int OPCODE = 4;
  localparam int NFU    = 7;
  localparam int RADDR  = 3;
  localparam int DEPTH  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                issue_valid = 1'b0;
  logic [OPCODE-1:0]   issue_opcode = '0;
  logic [RADDR-1:0]    issue_rd = '0;
  logic                issue_ready;
  logic                issue_illegal;
  logic [NFU-1:0]      fu_valid = '0;
  logic [NFU*DATA-1:0] fu_data = '0;
  logic [NFU-1:0]      fu_ack;
  logic                rd_wb_valid;
  logic [RADDR-1:0]    rd_wb_addr;
  logic [DATA-1:0]     rd_wb_data;
  logic                rd_wb_ready = 1'b1;
  logic                busy;

  typedef struct {
    logic [RADDR-1:0] addr;
    logic [DATA-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] bad_ops [3];

  rv16_rd_wbq #(
    .DATA   (DATA),
    .OPCODE (OPCODE),
    .NFU    (NFU),
    .RADDR  (RADDR),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_opcode  (issue_opcode),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .issue_illegal (issue_illegal),
    .fu_valid      (fu_valid),
    .fu_data       (fu_data),
    .fu_ack        (fu_ack),
    .rd_wb_valid   (rd_wb_valid),
    .rd_wb_addr    (rd_wb_addr),
    .rd_wb_data    (rd_wb_data),
    .rd_wb_ready   (rd_wb_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [RADDR-1:0] rd);
    issue_valid  = 1'b1;
    issue_opcode = op;
    issue_rd     = rd;
  endtask

  task automatic set_fu(input int ch, input logic [DATA-1:0] d);
    fu_valid[ch]           = 1'b1;
    fu_data[ch*DATA +: DATA] = d;
  endtask

  task automatic clr_fu(input int ch);
    fu_valid[ch] = 1'b0;
  endtask

  task automatic expect_wb(input logic [RADDR-1:0] rd, input logic [DATA-1:0] d);
    exp_t e;
    e.addr = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_wb_valid"}, rd_wb_valid, 0);
    chk({pfx, "_wb_addr"}, rd_wb_addr, 0);
    chk({pfx, "_wb_data"}, rd_wb_data, 0);
    chk({pfx, "_fu_ack"}, fu_ack, 0);
    chk({pfx, "_illegal"}, issue_illegal, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_issue_ready"}, issue_ready, 1);
  endtask

  // Present a result on one channel and hold it until acked, bounded.
  task automatic serve(input int ch, input logic [DATA-1:0] d);
    bit seen;
    seen = 1'b0;
    set_fu(ch, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fu_ack[ch]) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL serve_ack ch%0d: got no ack, expected ack within 20 cycles", ch);
    end
    cyc();
    clr_fu(ch);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s: got busy=%0b pending=%0d, expected idle with none pending",
               name, busy, exp_q.size());
    end
    cyc();
  endtask

  // Scoreboard monitor: every writeback handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rd_wb_valid && rd_wb_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_unexpected: got addr=%0d data=0x%0h, expected no writeback",
                 rd_wb_addr, rd_wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_addr", rd_wb_addr, e.addr);
        chk("wb_data", rd_wb_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    bad_ops = '{4'h7, 4'h9, 4'hF};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    cyc();
    rst = 1'b0;

    // ADD rd=2 with result already present: pop next cycle, writeback after
    issue(4'h0, 3'd2);
    set_fu(0, 16'h1234);
    expect_wb(3'd2, 16'h1234);
    @(negedge clk);
    chk("t1_ready", issue_ready, 1);
    chk("t1_no_ack_early", fu_ack, 0);
    cyc();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t1_ack", fu_ack, 7'b0000001);
    chk("t1_wbv_pre", rd_wb_valid, 0);
    cyc();
    clr_fu(0);
    @(negedge clk);
    chk("t1_wbv", rd_wb_valid, 1);
    chk("t1_ack_clear", fu_ack, 0);
    cyc();
    @(negedge clk);
    chk("t1_wbv_clear", rd_wb_valid, 0);
    chk("t1_busy", busy, 0);
    cyc();

    // MUL rd=1 then ADD rd=3; ADD result first must wait behind MUL
    issue(4'h2, 3'd1);
    expect_wb(3'd1, 16'hBEEF);
    cyc();
    issue(4'h0, 3'd3);
    expect_wb(3'd3, 16'h0042);
    set_fu(0, 16'h0042);
    cyc();
    issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_blocked_ack", fu_ack, 0);
      chk("t2_blocked_wbv", rd_wb_valid, 0);
      cyc();
    end
    set_fu(2, 16'hBEEF);
    @(negedge clk);
    chk("t2_ack_mul", fu_ack, 7'b0000100);
    cyc();
    clr_fu(2);
    @(negedge clk);
    chk("t2_ack_add", fu_ack, 7'b0000001);
    cyc();
    clr_fu(0);
    wait_idle("t2_idle");

    // Fill four tags, fifth refused, one pop reopens issue the cycle after
    issue(4'h4, 3'd4); expect_wb(3'd4, 16'h4444); cyc();
    issue(4'h5, 3'd5); expect_wb(3'd5, 16'h5555); cyc();
    issue(4'h6, 3'd6); expect_wb(3'd6, 16'h6666); cyc();
    issue(4'h1, 3'd7); expect_wb(3'd7, 16'h1111); cyc();
    issue(4'h0, 3'd0);
    @(negedge clk);
    chk("t3_full_ready", issue_ready, 0);
    chk("t3_busy", busy, 1);
    cyc();
    issue_valid = 1'b0;
    set_fu(4, 16'h4444);
    @(negedge clk);
    chk("t3_pop_ack", fu_ack, 7'b0010000);
    chk("t3_no_bypass", issue_ready, 0);
    cyc();
    clr_fu(4);
    @(negedge clk);
    chk("t3_ready_back", issue_ready, 1);
    cyc();
    serve(5, 16'h5555);
    serve(6, 16'h6666);
    serve(1, 16'h1111);
    wait_idle("t3_idle");

    // Illegal opcodes: one-cycle pulse, nothing queued
    for (int i = 0; i < 3; i++) begin
      issue(bad_ops[i], 3'd5);
      @(negedge clk);
      chk("t4_illegal_pre", issue_illegal, 0);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("t4_illegal_pulse", issue_illegal, 1);
      chk("t4_busy", busy, 0);
      chk("t4_ready", issue_ready, 1);
      cyc();
      @(negedge clk);
      chk("t4_illegal_end", issue_illegal, 0);
      cyc();
    end

    // Back-pressure: first writeback held stable, second ack withheld, then consecutive
    issue(4'h4, 3'd4);
    set_fu(4, 16'hA5A5);
    expect_wb(3'd4, 16'hA5A5);
    cyc();
    issue(4'h5, 3'd5);
    set_fu(5, 16'h5A5A);
    expect_wb(3'd5, 16'h5A5A);
    rd_wb_ready = 1'b0;
    @(negedge clk);
    chk("t5_ack_first", fu_ack, 7'b0010000);
    cyc();
    issue_valid = 1'b0;
    clr_fu(4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", rd_wb_valid, 1);
      chk("t5_hold_addr", rd_wb_addr, 4);
      chk("t5_hold_data", rd_wb_data, 16'hA5A5);
      chk("t5_hold_no_ack", fu_ack, 0);
      cyc();
    end
    rd_wb_ready = 1'b1;
    @(negedge clk);
    chk("t5_ack_second", fu_ack, 7'b0100000);
    cyc();
    clr_fu(5);
    @(negedge clk);
    chk("t5_second_valid", rd_wb_valid, 1);
    chk("t5_second_addr", rd_wb_addr, 5);
    cyc();
    @(negedge clk);
    chk("t5_drained", rd_wb_valid, 0);
    cyc();

    // Reset mid-operation with three queued tags and a pending writeback
    rd_wb_ready = 1'b0;
    issue(4'h0, 3'd1);
    set_fu(0, 16'h0101);
    cyc();
    issue(4'h1, 3'd2);
    @(negedge clk);
    chk("t6_ack_add", fu_ack, 7'b0000001);
    cyc();
    clr_fu(0);
    issue(4'h6, 3'd3);
    cyc();
    issue(4'h3, 3'd6);
    cyc();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t6_wbv_pending", rd_wb_valid, 1);
    chk("t6_busy", busy, 1);
    chk("t6_ready", issue_ready, 1);
    cyc();
    rst = 1'b1;
    rd_wb_ready = 1'b1;
    set_fu(1, 16'h2222);
    @(negedge clk);
    chk("t6_no_ack_in_rst", fu_ack, 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_reset("t6_post");
    cyc();
    clr_fu(1);
    @(negedge clk);
    chk("t6_no_ack_after", fu_ack, 0);
    chk("t6_idle", busy, 0);
    cyc();

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
